uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronised RX, 8N1 deframing and a small byte FIFO with valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits (8E1).
module uart_rx_ctrl #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DIV         = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_FW      = PTR_W + 1;
  localparam int SYNC_STAGES = 2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_FW-1:0] FIFO_FULL_CNT = CNT_FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------- input sync
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_prev_reg;
  logic                   rx_s;
  logic                   rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
      rx_prev_reg <= rx_s;
    end
  end

  assign rx_s    = sync_reg[SYNC_STAGES-1];
  assign rx_fall = rx_prev_reg & ~rx_s;

  // ---------------------------------------------------------------- receiver FSM
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             par_err_reg, par_err_next;
  logic             frame_err_reg, frame_err_next;
  logic             push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      par_err_reg   <= par_err_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    par_err_next   = par_err_reg;
    frame_err_next = 1'b0;
    push           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (rx_fall) begin
          state_next   = S_START;
          par_err_next = 1'b0;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          par_err_next = ^{rx_s, shift_reg};
          state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            frame_err_next = 1'b1;
            state_next     = S_WAIT_IDLE;
          end else if (par_err_reg) begin
            frame_err_next = 1'b1;
            state_next     = S_IDLE;
          end else begin
            push       = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A line held low (break) must return high before a new start bit counts.
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != S_IDLE);
  assign frame_err = frame_err_reg;

  // ---------------------------------------------------------------- byte FIFO
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_FW-1:0] count_reg, count_next, remaining;
  logic [7:0]        data_out_reg;
  logic              overflow_reg;
  logic              fifo_full, fifo_empty, do_pop, do_push, ovf_next;

  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign do_pop     = ready & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);
  assign ovf_next   = push & fifo_full & ~do_pop;
  assign remaining  = count_reg - CNT_FW'(do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (do_pop) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    count_next = count_reg;
    if (do_push && !do_pop) count_next = count_reg + CNT_FW'(1);
    else if (!do_push && do_pop) count_next = count_reg - CNT_FW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= ovf_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      // Head register: next stored entry, or the byte being written into an otherwise empty FIFO.
      if (remaining != '0) data_out_reg <= mem[rd_ptr_next];
      else if (do_push)    data_out_reg <= shift_reg;
    end
  end

  assign data_out = data_out_reg;
  assign valid    = ~fifo_empty;
  assign overflow = overflow_reg;

endmodule
